// File: rtl/rvfpm_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rvfpm_chk_pkg
//  Description : Shared types and constants for the RISC-V FP move/sign-inject
//                result checker: op-class enum (whose encoding doubles as the
//                reported mismatch code), OP-FP opcode/funct constants and
//                the delay-line entry struct.
//  Revision    : 1.0 - initial release
// ============================================================================
package rvfpm_chk_pkg;

    // Width of the expected-value field; FLEN/XLEN up to this value are
    // supported. Narrower configurations are zero-extended into it.
    localparam int CHK_DATA_W = 64;

    localparam logic [6:0] C_OPC_OP_FP   = 7'b1010011;

    localparam logic [6:0] C_F7_FMV_X_W  = 7'b1110000;
    localparam logic [6:0] C_F7_FMV_W_X  = 7'b1111000;
    localparam logic [6:0] C_F7_FSGNJ    = 7'b0010000;
    localparam logic [6:0] C_F7_FCLASS   = 7'b1110000;

    localparam logic [2:0] C_F3_FMV      = 3'b000;
    localparam logic [2:0] C_F3_FSGNJ    = 3'b000;
    localparam logic [2:0] C_F3_FSGNJN   = 3'b001;
    localparam logic [2:0] C_F3_FSGNJX   = 3'b010;
    localparam logic [2:0] C_F3_FCLASS   = 3'b001;

    // Encoding equals the mismatch_op code reported for a failing check.
    typedef enum logic [2:0] {
        OP_NONE    = 3'd0,
        OP_FMV_X_W = 3'd1,
        OP_FMV_W_X = 3'd2,
        OP_FSGNJ   = 3'd3,
        OP_FSGNJN  = 3'd4,
        OP_FSGNJX  = 3'd5,
        OP_FCLASS  = 3'd6,
        OP_WB_SEQ  = 3'd7   // spurious or missing writeback
    } chk_op_e;

    typedef struct packed {
        logic                  valid;
        chk_op_e               op;
        logic [4:0]            rd;
        logic                  wb_fp;
        logic [CHK_DATA_W-1:0] expected;
    } chk_entry_t;

    // FCLASS result shape: exactly one of the ten class bits set, the rest 0.
    function automatic logic fclass_shape_ok(input logic [CHK_DATA_W-1:0] d);
        return (d[CHK_DATA_W-1:10] == '0) && $onehot(d[9:0]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rvfpm_chk_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : rvfpm_chk_delay_line
//  Description : DEPTH-stage shift register of checker entries. Advances one
//                stage per cycle while enable_i is high and holds every stage
//                while it is low. Asynchronous active-low clear empties it.
//  Ports       : ck        - clock
//                rst       - asynchronous active-low clear
//                enable_i  - advance the line this cycle
//                entry_i   - entry entering stage 0
//                entry_o   - entry at the last (output) stage
//  Revision    : 1.0 - initial release
// ============================================================================
module rvfpm_chk_delay_line
    import rvfpm_chk_pkg::*;
#(
    parameter int DEPTH = 5
) (
    input  logic       ck,
    input  logic       rst,
    input  logic       enable_i,
    input  chk_entry_t entry_i,
    output chk_entry_t entry_o
);

    chk_entry_t stage_q [DEPTH];

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else if (enable_i) begin
            stage_q[0] <= entry_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign entry_o = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/rvfpm_result_checker.sv
`default_nettype none
// ============================================================================
//  Module      : rvfpm_result_checker
//  Description : Shadow checker for an FP unit's FMV.X.W / FMV.W.X / FSGNJ* /
//                FCLASS results. The expected result is computed when the
//                instruction issues, carried through a PIPELINE_STAGES+1 deep
//                delay line and compared against the DUT writeback when it
//                reaches the output stage. Failures produce a registered
//                one-cycle pulse with an error class; saturating counters
//                track completed checks and errors.
//  Config      : RVFPM_CHK_FCLASS_EN - when defined, FCLASS results are
//                checked for a valid class mask; otherwise FCLASS issues as a
//                bubble and code 6 is never reported.
//  Ports       : ck, rst         - clock, asynchronous active-low reset
//                enable          - DUT enable; low freezes the checker
//                instr_valid     - instruction issued this cycle
//                instruction     - issued instruction word
//                rs1_data/rs2_data - FP operands at issue
//                x_data_in       - integer operand at issue
//                wb_valid/wb_fp/wb_rd/wb_data - DUT writeback
//                mismatch/mismatch_op - one-cycle error pulse and class
//                error_cnt/checks_done - saturating counters
//  Revision    : 1.0 - initial release
// ============================================================================
module rvfpm_result_checker
    import rvfpm_chk_pkg::*;
#(
    parameter int FLEN            = 32,
    parameter int XLEN            = 32,
    parameter int PIPELINE_STAGES = 4,
    parameter int CNT_W           = 16
) (
    input  logic                                   ck,
    input  logic                                   rst,
    input  logic                                   enable,
    input  logic                                   instr_valid,
    input  logic [31:0]                            instruction,
    input  logic [FLEN-1:0]                        rs1_data,
    input  logic [FLEN-1:0]                        rs2_data,
    input  logic [XLEN-1:0]                        x_data_in,
    input  logic                                   wb_valid,
    input  logic                                   wb_fp,
    input  logic [4:0]                             wb_rd,
    input  logic [((FLEN > XLEN) ? FLEN : XLEN)-1:0] wb_data,
    output logic                                   mismatch,
    output logic [2:0]                             mismatch_op,
    output logic [CNT_W-1:0]                       error_cnt,
    output logic [CNT_W-1:0]                       checks_done
);

    // Keeps FMV.W.X to the low FLEN bits of the integer operand.
    localparam logic [CHK_DATA_W-1:0] C_FLEN_MASK =
        (FLEN >= CHK_DATA_W) ? {CHK_DATA_W{1'b1}}
                             : ((CHK_DATA_W'(1) << FLEN) - CHK_DATA_W'(1));

    // ------------------------------------------------------------------
    // Issue decode and expected-value computation
    // ------------------------------------------------------------------
    logic [6:0]      w_opcode;
    logic [6:0]      w_funct7;
    logic [2:0]      w_funct3;
    chk_op_e         w_issue_op;
    chk_entry_t      w_issue_entry;
    logic            w_rs1_sign;
    logic            w_rs2_sign;
    logic            w_unused_fields;

    assign w_opcode   = instruction[6:0];
    assign w_funct3   = instruction[14:12];
    assign w_funct7   = instruction[31:25];
    assign w_rs1_sign = rs1_data[FLEN-1];
    assign w_rs2_sign = rs2_data[FLEN-1];

    // Register-index fields are irrelevant: operand values arrive directly.
    assign w_unused_fields = ^{instruction[24:15], rs2_data[FLEN-2:0]};

    always_comb begin
        w_issue_op = OP_NONE;
        if (enable && instr_valid && (w_opcode == C_OPC_OP_FP)) begin
            case ({w_funct7, w_funct3})
                {C_F7_FMV_X_W, C_F3_FMV}:    w_issue_op = OP_FMV_X_W;
                {C_F7_FMV_W_X, C_F3_FMV}:    w_issue_op = OP_FMV_W_X;
                {C_F7_FSGNJ,   C_F3_FSGNJ}:  w_issue_op = OP_FSGNJ;
                {C_F7_FSGNJ,   C_F3_FSGNJN}: w_issue_op = OP_FSGNJN;
                {C_F7_FSGNJ,   C_F3_FSGNJX}: w_issue_op = OP_FSGNJX;
`ifdef RVFPM_CHK_FCLASS_EN
                {C_F7_FCLASS,  C_F3_FCLASS}: w_issue_op = OP_FCLASS;
`endif
                default:                     w_issue_op = OP_NONE;
            endcase
        end
    end

    always_comb begin
        w_issue_entry       = '0;
        w_issue_entry.valid = (w_issue_op != OP_NONE);
        w_issue_entry.op    = w_issue_op;
        w_issue_entry.rd    = instruction[11:7];
        case (w_issue_op)
            OP_FMV_X_W: begin
                w_issue_entry.wb_fp    = 1'b0;
                w_issue_entry.expected = CHK_DATA_W'(rs1_data);
            end
            OP_FMV_W_X: begin
                w_issue_entry.wb_fp    = 1'b1;
                w_issue_entry.expected = CHK_DATA_W'(x_data_in) & C_FLEN_MASK;
            end
            OP_FSGNJ: begin
                w_issue_entry.wb_fp    = 1'b1;
                w_issue_entry.expected =
                    CHK_DATA_W'({w_rs2_sign, rs1_data[FLEN-2:0]});
            end
            OP_FSGNJN: begin
                w_issue_entry.wb_fp    = 1'b1;
                w_issue_entry.expected =
                    CHK_DATA_W'({~w_rs2_sign, rs1_data[FLEN-2:0]});
            end
            OP_FSGNJX: begin
                w_issue_entry.wb_fp    = 1'b1;
                w_issue_entry.expected =
                    CHK_DATA_W'({w_rs1_sign ^ w_rs2_sign, rs1_data[FLEN-2:0]});
            end
            default: begin
                // FCLASS writes an X register; its value is shape-checked.
                w_issue_entry.wb_fp    = 1'b0;
                w_issue_entry.expected = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Delay line
    // ------------------------------------------------------------------
    chk_entry_t w_out_entry;

    rvfpm_chk_delay_line #(
        .DEPTH (PIPELINE_STAGES + 1)
    ) u_delay_line (
        .ck       (ck),
        .rst      (rst),
        .enable_i (enable),
        .entry_i  (w_issue_entry),
        .entry_o  (w_out_entry)
    );

    // ------------------------------------------------------------------
    // Output-stage comparison
    // ------------------------------------------------------------------
    logic [CHK_DATA_W-1:0] w_wb_ext;
    logic                  w_fields_ok;
    logic                  w_check;
    logic                  w_flag;
    chk_op_e               w_code;

    assign w_wb_ext    = CHK_DATA_W'(wb_data);
    assign w_fields_ok = (wb_rd == w_out_entry.rd) &&
                         (wb_fp == w_out_entry.wb_fp) &&
                         (w_wb_ext == w_out_entry.expected);

`ifdef RVFPM_CHK_FCLASS_EN
    logic w_fclass_ok;
    assign w_fclass_ok = (wb_rd == w_out_entry.rd) && !wb_fp &&
                         fclass_shape_ok(w_wb_ext);
`endif

    always_comb begin
        w_check = 1'b0;
        w_flag  = 1'b0;
        w_code  = OP_NONE;
        if (enable) begin
            if (w_out_entry.valid) begin
                w_check = 1'b1;
                if (!wb_valid) begin
                    w_flag = 1'b1;
                    w_code = OP_WB_SEQ;
`ifdef RVFPM_CHK_FCLASS_EN
                end else if (w_out_entry.op == OP_FCLASS) begin
                    if (!w_fclass_ok) begin
                        w_flag = 1'b1;
                        w_code = OP_FCLASS;
                    end
`endif
                end else if (!w_fields_ok) begin
                    w_flag = 1'b1;
                    w_code = w_out_entry.op;
                end
            end else if (wb_valid) begin
                w_flag = 1'b1;
                w_code = OP_WB_SEQ;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered report and saturating counters
    // ------------------------------------------------------------------
    logic             mismatch_q;
    logic             mismatch_d;
    chk_op_e          mismatch_op_q;
    chk_op_e          mismatch_op_d;
    logic [CNT_W-1:0] error_cnt_q;
    logic [CNT_W-1:0] error_cnt_d;
    logic [CNT_W-1:0] checks_done_q;
    logic [CNT_W-1:0] checks_done_d;

    always_comb begin
        mismatch_d    = w_flag;
        mismatch_op_d = w_code;
        error_cnt_d   = error_cnt_q;
        checks_done_d = checks_done_q;
        if (w_flag && (error_cnt_q != {CNT_W{1'b1}})) begin
            error_cnt_d = error_cnt_q + CNT_W'(1);
        end
        if (w_check && (checks_done_q != {CNT_W{1'b1}})) begin
            checks_done_d = checks_done_q + CNT_W'(1);
        end
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            mismatch_q    <= 1'b0;
            mismatch_op_q <= OP_NONE;
            error_cnt_q   <= '0;
            checks_done_q <= '0;
        end else begin
            mismatch_q    <= mismatch_d;
            mismatch_op_q <= mismatch_op_d;
            error_cnt_q   <= error_cnt_d;
            checks_done_q <= checks_done_d;
        end
    end

    assign mismatch    = mismatch_q;
    assign mismatch_op = mismatch_op_q;
    assign error_cnt   = error_cnt_q;
    assign checks_done = checks_done_q;

endmodule
`default_nettype wire

// File: tb/tb_rvfpm_result_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rvfpm_result_checker
//  Description : Scoreboard bench for rvfpm_result_checker. Two instances
//                (16-bit and 4-bit counters) share one stimulus stream. The
//                reference model keeps a queue of outstanding results keyed by
//                the enabled-cycle index at which they fall due; each cycle's
//                expected report is queued and a monitor compares it one
//                clock edge later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rvfpm_result_checker;

    localparam int PS = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en, iv, wv, wfp;
    logic [31:0] ins, a, b, x, wd;
    logic [4:0]  wrd;

    logic        mm16, mm4;
    logic [2:0]  op16, op4;
    logic [15:0] err16, chk16;
    logic [3:0]  err4, chk4;

    rvfpm_result_checker #(.FLEN(32), .XLEN(32), .PIPELINE_STAGES(PS), .CNT_W(16)) dut (
        .ck(clk), .rst(rst_n), .enable(en), .instr_valid(iv), .instruction(ins),
        .rs1_data(a), .rs2_data(b), .x_data_in(x), .wb_valid(wv), .wb_fp(wfp),
        .wb_rd(wrd), .wb_data(wd), .mismatch(mm16), .mismatch_op(op16),
        .error_cnt(err16), .checks_done(chk16));

    rvfpm_result_checker #(.FLEN(32), .XLEN(32), .PIPELINE_STAGES(PS), .CNT_W(4)) dut_sat (
        .ck(clk), .rst(rst_n), .enable(en), .instr_valid(iv), .instruction(ins),
        .rs1_data(a), .rs2_data(b), .x_data_in(x), .wb_valid(wv), .wb_fp(wfp),
        .wb_rd(wrd), .wb_data(wd), .mismatch(mm4), .mismatch_op(op4),
        .error_cnt(err4), .checks_done(chk4));

    typedef struct {
        longint      due;
        int          op;
        logic [4:0]  rd;
        logic        fp;
        logic [31:0] data;
    } pend_t;

    typedef struct {
        logic mm;
        int   code;
        int   e16, c16, e4, c4;
    } exp_t;

    pend_t  pend[$];
    exp_t   sb[$];
    int     n_checks = 0;
    int     n_errors = 0;
    longint ecount   = 0;
    int     m_err    = 0;
    int     m_chk    = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b1010011};
    endfunction

    // Op code from the instruction word (0 = not a checked instruction).
    function automatic int decode(input logic [31:0] i);
        if (i[6:0] != 7'b1010011) return 0;
        case ({i[31:25], i[14:12]})
            {7'b1110000, 3'b000}: return 1;
            {7'b1111000, 3'b000}: return 2;
            {7'b0010000, 3'b000}: return 3;
            {7'b0010000, 3'b001}: return 4;
            {7'b0010000, 3'b010}: return 5;
`ifdef RVFPM_CHK_FCLASS_EN
            {7'b1110000, 3'b001}: return 6;
`endif
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] result_of(input int op, input logic [31:0] r1,
                                              input logic [31:0] r2, input logic [31:0] xi);
        case (op)
            1: return r1;
            2: return xi;
            3: return {r2[31], r1[30:0]};
            4: return {~r2[31], r1[30:0]};
            5: return {r1[31] ^ r2[31], r1[30:0]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic int judge(input pend_t p);
        if (!wv) return 7;
        if (p.op == 6)
            return (wrd == p.rd && !wfp && wd[31:10] == 22'h0 && $countones(wd[9:0]) == 1) ? 0 : 6;
        return (wrd == p.rd && wfp == p.fp && wd == p.data) ? 0 : p.op;
    endfunction

    // Models the upcoming clock edge from the currently driven inputs,
    // queues the expected report, then advances to the next falling edge.
    task automatic tick();
        exp_t  e;
        pend_t p;
        int    code;
        int    op;
        code = 0;
        if (rst_n && en) begin
            if (pend.size() > 0 && pend[0].due == ecount) begin
                p = pend.pop_front();
                m_chk++;
                code = judge(p);
            end else if (wv) begin
                code = 7;
            end
            if (code != 0) m_err++;
            if (iv) begin
                op = decode(ins);
                if (op != 0) begin
                    p.due  = ecount + PS + 1;
                    p.op   = op;
                    p.rd   = ins[11:7];
                    p.fp   = (op >= 2 && op <= 5);
                    p.data = result_of(op, a, b, x);
                    pend.push_back(p);
                end
            end
            ecount++;
        end
        e.mm   = (code != 0);
        e.code = code;
        e.e16  = (m_err > 65535) ? 65535 : m_err;
        e.c16  = (m_chk > 65535) ? 65535 : m_chk;
        e.e4   = (m_err > 15) ? 15 : m_err;
        e.c4   = (m_chk > 15) ? 15 : m_chk;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic set_idle();
        en = 1'b1; iv = 1'b0; ins = 32'h0; a = 32'h0; b = 32'h0; x = 32'h0;
        wv = 1'b0; wfp = 1'b0; wrd = 5'd0; wd = 32'h0;
    endtask

    // Asynchronous reset asserted mid-cycle, checked immediately, held one edge.
    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        pend.delete();
        m_err = 0;
        m_chk = 0;
        #1;
        check("rst_mm",  mm16,  0);
        check("rst_op",  op16,  0);
        check("rst_err", err16, 0);
        check("rst_chk", chk16, 0);
        check("rst_err4", err4, 0);
        check("rst_chk4", chk4, 0);
        tick();
        rst_n = 1'b1;
    endtask

    // Monitor: compares each edge's report against the scoreboard.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("mismatch",     mm16,  e.mm);
                check("mismatch_op",  op16,  e.code);
                check("error_cnt",    err16, e.e16);
                check("checks_done",  chk16, e.c16);
                check("mismatch4",    mm4,   e.mm);
                check("mismatch_op4", op4,   e.code);
                check("error_cnt4",   err4,  e.e4);
                check("checks_done4", chk4,  e.c4);
            end
        end
    end

    initial begin : stimulus
        pend_t p;
        int    r;
        rst_n = 1'b0;
        set_idle();
        @(negedge clk);
        do_reset();

        // FSGNJX: sign 0 xor 1 -> 0xBF800000 to f3 five cycles later
        iv = 1'b1; ins = enc(7'b0010000, 3'b010, 5'd3); a = 32'h3F800000; b = 32'h80000000;
        tick();
        set_idle();
        repeat (4) tick();
        wv = 1'b1; wfp = 1'b1; wrd = 5'd3; wd = 32'hBF800000;
        tick();
        set_idle();
        check("sgnjx_mm",  mm16,  0);
        check("sgnjx_chk", chk16, 1);
        check("sgnjx_err", err16, 0);

        // FMV.W.X with a wrong writeback value
        do_reset();
        iv = 1'b1; ins = enc(7'b1111000, 3'b000, 5'd5); x = 32'h12345678;
        tick();
        set_idle();
        repeat (4) tick();
        wv = 1'b1; wfp = 1'b1; wrd = 5'd5; wd = 32'h12345679;
        tick();
        set_idle();
        check("fmvwx_mm",  mm16,  1);
        check("fmvwx_op",  op16,  2);
        check("fmvwx_err", err16, 1);

        // FSGNJ with a 3-cycle stall: correct writeback at +8
        do_reset();
        iv = 1'b1; ins = enc(7'b0010000, 3'b000, 5'd7); a = 32'h40490FDB; b = 32'h80000000;
        tick();
        set_idle(); tick();
        en = 1'b0; repeat (3) tick();
        set_idle(); repeat (3) tick();
        wv = 1'b1; wfp = 1'b1; wrd = 5'd7; wd = 32'hC0490FDB;
        tick();
        set_idle();
        check("stall_mm",  mm16,  0);
        check("stall_chk", chk16, 1);
        check("stall_err", err16, 0);

        // Same stall, writeback too early at +5: spurious then missing
        do_reset();
        iv = 1'b1; ins = enc(7'b0010000, 3'b000, 5'd7); a = 32'h40490FDB; b = 32'h80000000;
        tick();
        set_idle(); tick();
        en = 1'b0; repeat (3) tick();
        set_idle();
        wv = 1'b1; wfp = 1'b1; wrd = 5'd7; wd = 32'hC0490FDB;
        tick();
        set_idle();
        check("early_mm", mm16, 1);
        check("early_op", op16, 7);
        repeat (2) tick();
        tick();
        check("missing_op",  op16,  7);
        check("missing_err", err16, 2);

        // FCLASS with two class bits set
        do_reset();
        iv = 1'b1; ins = enc(7'b1110000, 3'b001, 5'd9); a = 32'hFF800000;
        tick();
        set_idle();
        repeat (4) tick();
        wv = 1'b1; wfp = 1'b0; wrd = 5'd9; wd = 32'h00000041;
        tick();
        set_idle();
`ifdef RVFPM_CHK_FCLASS_EN
        check("fclass_op",  op16,  6);
        check("fclass_chk", chk16, 1);
`else
        check("fclass_no6", (op16 == 3'd6), 0);
        check("fclass_chk", chk16, 0);
`endif

        // Reset two cycles after an FMV.X.W issue discards it unchecked
        iv = 1'b1; ins = enc(7'b1110000, 3'b000, 5'd4); a = 32'hCAFEF00D;
        tick();
        set_idle(); tick();
        do_reset();
        repeat (5) tick();
        check("flush_chk", chk16, 0);
        check("flush_err", err16, 0);

        // Twenty spurious writebacks: 4-bit counter saturates at 15
        do_reset();
        wv = 1'b1; wfp = 1'b1; wrd = 5'd1; wd = 32'h1;
        repeat (20) tick();
        set_idle(); tick();
        check("sat_err4",  err4,  15);
        check("sat_err16", err16, 20);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 600; n++) begin
            set_idle();
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 1) == 1) begin
                iv = 1'b1;
                r  = $urandom_range(0, 6);
                case (r)
                    0: ins = enc(7'b1110000, 3'b000, 5'($urandom));
                    1: ins = enc(7'b1111000, 3'b000, 5'($urandom));
                    2: ins = enc(7'b0010000, 3'b000, 5'($urandom));
                    3: ins = enc(7'b0010000, 3'b001, 5'($urandom));
                    4: ins = enc(7'b0010000, 3'b010, 5'($urandom));
                    5: ins = enc(7'b1110000, 3'b001, 5'($urandom));
                    default: ins = $urandom;
                endcase
                a = $urandom; b = $urandom; x = $urandom;
            end
            if (en && pend.size() > 0 && pend[0].due == ecount) begin
                p   = pend[0];
                wv  = 1'b1;
                wrd = p.rd;
                wfp = p.fp;
                wd  = (p.op == 6) ? (32'h1 << $urandom_range(0, 9)) : p.data;
                r   = $urandom_range(0, 9);
                if (r == 7) wv  = 1'b0;
                if (r == 8) wd  = wd ^ (32'h1 << $urandom_range(0, 31));
                if (r == 9) begin
                    if ($urandom_range(0, 1) == 1) wrd = wrd ^ 5'd1;
                    else                           wfp = ~wfp;
                end
            end else if (!en || $urandom_range(0, 19) == 0) begin
                wv = 1'b1; wfp = 1'($urandom); wrd = 5'($urandom); wd = $urandom;
            end
            tick();
        end

        set_idle();
        repeat (8) tick();
        check("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rvfpm_result_checker.md
RVFPM_RESULT_CHECKER -- requirements
Module: rvfpm_result_checker

Interface
REQ-001 Parameter FLEN, default 32, FP register width in bits.
REQ-002 Parameter XLEN, default 32, integer register width in bits.
REQ-003 Parameter PIPELINE_STAGES, default 4, DUT latency; result expected PIPELINE_STAGES+1 enabled cycles after issue.
REQ-004 Parameter CNT_W, default 16, counter width.
REQ-005 ck  input  1  clock; all state on posedge ck.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 enable  input  1  DUT enable; low freezes the checker.
REQ-008 instr_valid  input  1  instruction issued this cycle.
REQ-009 instruction  input  32  issued RISC-V instruction word.
REQ-010 rs1_data, rs2_data  input  FLEN each  FP register values of rs1/rs2 at issue.
REQ-011 x_data_in  input  XLEN  integer operand from X register at issue.
REQ-012 wb_valid  input  1  DUT writeback this cycle.
REQ-013 wb_fp  input  1  1 = FP register write, 0 = X register write.
REQ-014 wb_rd  input  5  writeback destination index.
REQ-015 wb_data  input  max(FLEN,XLEN)  writeback value.
REQ-016 mismatch  output  1  one-cycle error pulse.
REQ-017 mismatch_op  output  3  error class: 0 none, 1 FMV.X.W, 2 FMV.W.X, 3 FSGNJ, 4 FSGNJN, 5 FSGNJX, 6 FCLASS, 7 spurious/missing writeback.
REQ-018 error_cnt, checks_done  output  CNT_W each  saturating error and completed-check counters.

Function
REQ-019 Issue decode (opcode 1010011, instr_valid=1, enable=1): funct7/funct3 1110000/000 FMV.X.W, 1111000/000 FMV.W.X, 0010000/000,001,010 FSGNJ/FSGNJN/FSGNJX, 1110000/001 FCLASS; any other instruction SHALL push a bubble.
REQ-020 Expected value computed at issue: FMV.X.W = rs1_data; FMV.W.X = x_data_in[FLEN-1:0]; FSGNJ* = {sign', rs1_data[FLEN-2:0]} with sign' = rs2 sign / inverted rs2 sign / rs1 sign XOR rs2 sign.
REQ-021 Each entry {valid, op, rd, wb_fp_exp, expected} SHALL shift one stage per cycle with enable=1 through a PIPELINE_STAGES+1 deep delay line; enable=0 holds every stage and suppresses all checks.
REQ-022 At the output stage, valid entry: wb_valid SHALL be 1 and wb_rd, wb_fp, wb_data SHALL match; FCLASS instead requires exactly one set bit in wb_data[9:0], all higher bits zero, wb_fp=0.
REQ-023 Output-stage entry valid with wb_valid=0, or wb_valid=1 with invalid entry, SHALL flag mismatch_op=7.
REQ-024 mismatch and mismatch_op SHALL be registered, asserted the cycle after the failing slot, held one cycle, otherwise 0.
REQ-025 checks_done SHALL increment once per valid output-stage entry; error_cnt once per flagged slot; both saturate at 2^CNT_W-1.
REQ-026 Issue and output-stage check in the same cycle SHALL both take effect (delay line full every cycle is legal).

Reset
REQ-027 rst low SHALL immediately clear all delay-line valid bits, mismatch=0, mismatch_op=0, error_cnt=0, checks_done=0; instructions in flight are discarded unchecked.
REQ-028 First issue accepted on the first posedge ck after rst deasserts.

Configuration
REQ-029 Macro RVFPM_CHK_FCLASS_EN defined: FCLASS checked per REQ-022; undefined: FCLASS pushes a bubble and code 6 is never produced.

Structure
REQ-030 Package rvfpm_chk_pkg SHALL hold the op-class enum, opcode/funct constants and the delay-line entry struct.
REQ-031 Sub-module rvfpm_chk_delay_line SHALL implement the parametrised, enable-stalled shift register with asynchronous clear.

Verification
REQ-032 FSGNJX rd=3, rs1=0x3F800000, rs2=0x80000000, DUT writes FP x3=0xBF800000 at +5 cycles -> no mismatch, checks_done=1, error_cnt=0.
REQ-033 FMV.W.X x_data_in=0x12345678, DUT writes 0x12345679 -> mismatch pulse, mismatch_op=2, error_cnt=1.
REQ-034 FSGNJ issued, enable low 3 cycles mid-flight, writeback at +8 cycles -> no mismatch; writeback at +5 -> mismatch_op=7 twice (spurious, then missing).
REQ-035 FCLASS with wb_data=0x0000_0041, macro defined -> mismatch_op=6; macro undefined -> no check, checks_done unchanged.
REQ-036 Issue FMV.X.W, drive rst low at +2 cycles for 1 cycle -> all outputs 0, no check at +5; CNT_W=4 with 20 forced errors -> error_cnt=15.
